// File: rtl/bus_arbiter_pkg.sv
// Shared types and constants for the two-requester bus arbiter.
package bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

  localparam logic REQ_CORE   = 1'b0;
  localparam logic REQ_LOADER = 1'b1;

  localparam int CNT_W = 3;

endpackage

// File: rtl/bus_arbiter_select.sv
// Winner selection between the core and loader requesters.
// ROUND_ROBIN_EN: alternate on contention using a last-owner pointer; otherwise core has fixed priority.
module bus_arbiter_select
  import bus_arbiter_pkg::*;
(
`ifdef ROUND_ROBIN_EN
  input  logic clk,
  input  logic reset,
  input  logic grant_en,
`endif
  input  logic req0,
  input  logic req1,
  output logic winner
);

`ifdef ROUND_ROBIN_EN
  logic last_q;
  logic last_d;

  // On contention, the requester that was not served last wins.
  always_comb begin
    winner = REQ_CORE;
    if (req0 && req1) begin
      winner = ~last_q;
    end else if (req1) begin
      winner = REQ_LOADER;
    end else begin
      winner = REQ_CORE;
    end
  end

  always_comb begin
    last_d = last_q;
    if (grant_en) begin
      last_d = winner;
    end else begin
      last_d = last_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_q <= REQ_CORE;
    end else begin
      last_q <= last_d;
    end
  end
`else
  always_comb begin
    winner = REQ_CORE;
    if (!req0 && req1) begin
      winner = REQ_LOADER;
    end else begin
      winner = REQ_CORE;
    end
  end
`endif

endmodule

// File: rtl/bus_arbiter.sv
// Two-requester shared-memory arbiter: IDLE -> ACCESS -> (WAIT) -> RESP FSM and datapath.
// Optional macro ROUND_ROBIN_EN selects round-robin instead of fixed core priority.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  m0_read,
  input  logic                  m0_write,
  input  logic [ADDR_WIDTH-1:0] m0_address,
  input  logic [DATA_WIDTH-1:0] m0_write_data,
  output logic [DATA_WIDTH-1:0] m0_read_data,
  output logic                  m0_ack,
  input  logic                  m1_read,
  input  logic                  m1_write,
  input  logic [ADDR_WIDTH-1:0] m1_address,
  input  logic [DATA_WIDTH-1:0] m1_write_data,
  output logic [DATA_WIDTH-1:0] m1_read_data,
  output logic                  m1_ack,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  input  logic [DATA_WIDTH-1:0] mem_read_data,
  output logic                  grant,
  output logic                  busy
);

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  grant_q, grant_d;
  logic                  is_wr_q, is_wr_d;
  logic                  busy_q, busy_d;
  logic                  mem_read_q, mem_read_d;
  logic                  mem_write_q, mem_write_d;
  logic                  m0_ack_q, m0_ack_d;
  logic                  m1_ack_q, m1_ack_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] m0_rdata_q, m0_rdata_d;
  logic [DATA_WIDTH-1:0] m1_rdata_q, m1_rdata_d;

  logic req0, req1, any_req, winner, win_write;

  assign req0      = m0_read | m0_write;
  assign req1      = m1_read | m1_write;
  assign any_req   = req0 | req1;
  assign win_write = (winner == REQ_LOADER) ? m1_write : m0_write;

`ifdef ROUND_ROBIN_EN
  logic grant_en;
  assign grant_en = (state_q == ST_IDLE) && any_req;
`endif

  bus_arbiter_select u_select (
`ifdef ROUND_ROBIN_EN
    .clk      (clk),
    .reset    (reset),
    .grant_en (grant_en),
`endif
    .req0     (req0),
    .req1     (req1),
    .winner   (winner)
  );

  // Strobes and acks are computed one state early so they leave the flops aligned with ACCESS/RESP.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    grant_d     = grant_q;
    is_wr_d     = is_wr_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    m0_rdata_d  = m0_rdata_q;
    m1_rdata_d  = m1_rdata_q;
    mem_read_d  = 1'b0;
    mem_write_d = 1'b0;
    m0_ack_d    = 1'b0;
    m1_ack_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          grant_d     = winner;
          is_wr_d     = win_write;
          addr_d      = (winner == REQ_LOADER) ? m1_address : m0_address;
          wdata_d     = (winner == REQ_LOADER) ? m1_write_data : m0_write_data;
          mem_write_d = win_write;
          mem_read_d  = ~win_write;
          state_d     = ST_ACCESS;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        if (is_wr_q) begin
          m0_ack_d = (grant_q == REQ_CORE);
          m1_ack_d = (grant_q == REQ_LOADER);
          state_d  = ST_RESP;
        end else begin
          cnt_d   = CNT_W'(READ_LATENCY);
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q <= 3'd1) begin
          if (grant_q == REQ_LOADER) begin
            m1_rdata_d = mem_read_data;
          end else begin
            m0_rdata_d = mem_read_data;
          end
          m0_ack_d = (grant_q == REQ_CORE);
          m1_ack_d = (grant_q == REQ_LOADER);
          cnt_d    = 3'd0;
          state_d  = ST_RESP;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 3'd0;
      grant_q     <= REQ_CORE;
      is_wr_q     <= 1'b0;
      busy_q      <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      m0_ack_q    <= 1'b0;
      m1_ack_q    <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      m0_rdata_q  <= '0;
      m1_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      grant_q     <= grant_d;
      is_wr_q     <= is_wr_d;
      busy_q      <= busy_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      m0_ack_q    <= m0_ack_d;
      m1_ack_q    <= m1_ack_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      m0_rdata_q  <= m0_rdata_d;
      m1_rdata_q  <= m1_rdata_d;
    end
  end

  assign m0_read_data   = m0_rdata_q;
  assign m1_read_data   = m1_rdata_q;
  assign m0_ack         = m0_ack_q;
  assign m1_ack         = m1_ack_q;
  assign mem_read       = mem_read_q;
  assign mem_write      = mem_write_q;
  assign mem_address    = addr_q;
  assign mem_write_data = wdata_q;
  assign grant          = grant_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: one instance at READ_LATENCY=1, one at READ_LATENCY=3.
module tb_bus_arbiter;

  logic clk = 1'b0;
  logic reset;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  // Instance with READ_LATENCY = 1
  logic        m0_read, m0_write, m1_read, m1_write;
  logic [31:0] m0_address, m0_write_data, m1_address, m1_write_data;
  logic [31:0] m0_read_data, m1_read_data;
  logic        m0_ack, m1_ack, mem_read, mem_write, grant, busy;
  logic [31:0] mem_address, mem_write_data, mem_read_data;
  logic [31:0] mem_val1;
  logic        pipe1 = 1'b0;

  bus_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .READ_LATENCY(1)) dut1 (
    .clk(clk), .reset(reset),
    .m0_read(m0_read), .m0_write(m0_write), .m0_address(m0_address),
    .m0_write_data(m0_write_data), .m0_read_data(m0_read_data), .m0_ack(m0_ack),
    .m1_read(m1_read), .m1_write(m1_write), .m1_address(m1_address),
    .m1_write_data(m1_write_data), .m1_read_data(m1_read_data), .m1_ack(m1_ack),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data),
    .grant(grant), .busy(busy)
  );

  // Memory model: data is valid only exactly one cycle after the strobe.
  always @(posedge clk) pipe1 <= mem_read;
  assign mem_read_data = pipe1 ? mem_val1 : 32'h0BAD0BAD;

  // Instance with READ_LATENCY = 3
  logic        d3_m0_read, d3_m0_write, d3_m1_read, d3_m1_write;
  logic [31:0] d3_m0_address, d3_m0_write_data, d3_m1_address, d3_m1_write_data;
  logic [31:0] d3_m0_read_data, d3_m1_read_data;
  logic        d3_m0_ack, d3_m1_ack, d3_mem_read, d3_mem_write, d3_grant, d3_busy;
  logic [31:0] d3_mem_address, d3_mem_write_data, d3_mem_read_data;
  logic [2:0]  pipe3 = 3'b000;

  bus_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .READ_LATENCY(3)) dut3 (
    .clk(clk), .reset(reset),
    .m0_read(d3_m0_read), .m0_write(d3_m0_write), .m0_address(d3_m0_address),
    .m0_write_data(d3_m0_write_data), .m0_read_data(d3_m0_read_data), .m0_ack(d3_m0_ack),
    .m1_read(d3_m1_read), .m1_write(d3_m1_write), .m1_address(d3_m1_address),
    .m1_write_data(d3_m1_write_data), .m1_read_data(d3_m1_read_data), .m1_ack(d3_m1_ack),
    .mem_read(d3_mem_read), .mem_write(d3_mem_write), .mem_address(d3_mem_address),
    .mem_write_data(d3_mem_write_data), .mem_read_data(d3_mem_read_data),
    .grant(d3_grant), .busy(d3_busy)
  );

  always @(posedge clk) pipe3 <= {pipe3[1:0], d3_mem_read};
  assign d3_mem_read_data = pipe3[2] ? 32'h3C3C3C3C : 32'h0BAD0BAD;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  logic exp_g;
  int   n;

  initial begin
    reset = 1'b1;
    {m0_read, m0_write, m1_read, m1_write} = 4'b0000;
    m0_address = 32'h0; m0_write_data = 32'h0; m1_address = 32'h0; m1_write_data = 32'h0;
    {d3_m0_read, d3_m0_write, d3_m1_read, d3_m1_write} = 4'b0000;
    d3_m0_address = 32'h0; d3_m0_write_data = 32'h0; d3_m1_address = 32'h0; d3_m1_write_data = 32'h0;
    mem_val1 = 32'h0;
    tick(); tick();
    chk("rst_grant", {31'h0, grant}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_strobes", {30'h0, mem_read, mem_write}, 32'h0);
    chk("rst_acks", {30'h0, m0_ack, m1_ack}, 32'h0);
    chk("rst_m0_rdata", m0_read_data, 32'h0);
    chk("rst_mem_addr", mem_address, 32'h0);
    chk("rst_mem_wdata", mem_write_data, 32'h0);
    chk("rst_d3_busy", {31'h0, d3_busy}, 32'h0);
    reset = 1'b0;
    tick();

    // m0 read, latency 1
    mem_val1 = 32'hDEADBEEF; m0_address = 32'h00000010; m0_read = 1'b1;
    tick();
    chk("rd_strobe", {31'h0, mem_read}, 32'h1);
    chk("rd_no_wr", {31'h0, mem_write}, 32'h0);
    chk("rd_addr", mem_address, 32'h00000010);
    chk("rd_busy", {31'h0, busy}, 32'h1);
    chk("rd_grant", {31'h0, grant}, 32'h0);
    tick();
    chk("rd_wait_ack", {31'h0, m0_ack}, 32'h0);
    chk("rd_strobe_once", {31'h0, mem_read}, 32'h0);
    tick();
    chk("rd_ack", {31'h0, m0_ack}, 32'h1);
    chk("rd_ack_other", {31'h0, m1_ack}, 32'h0);
    chk("rd_data", m0_read_data, 32'hDEADBEEF);
    m0_read = 1'b0;
    tick();
    chk("rd_ack_pulse", {31'h0, m0_ack}, 32'h0);
    chk("rd_idle_busy", {31'h0, busy}, 32'h0);

    // m0 read+write together behaves as a write
    m0_read = 1'b1; m0_write = 1'b1; m0_address = 32'h00000030; m0_write_data = 32'hA5A5A5A5;
    tick();
    chk("rw_write", {31'h0, mem_write}, 32'h1);
    chk("rw_no_read", {31'h0, mem_read}, 32'h0);
    chk("rw_wdata", mem_write_data, 32'hA5A5A5A5);
    chk("rw_addr", mem_address, 32'h00000030);
    tick();
    chk("rw_ack", {31'h0, m0_ack}, 32'h1);
    chk("rw_rdata_hold", m0_read_data, 32'hDEADBEEF);
    m0_read = 1'b0; m0_write = 1'b0;
    tick();
    chk("rw_ack_pulse", {31'h0, m0_ack}, 32'h0);

    // m1 write
    m1_write = 1'b1; m1_address = 32'h00000020; m1_write_data = 32'h12345678;
    tick();
    chk("wr_strobe", {31'h0, mem_write}, 32'h1);
    chk("wr_no_read", {31'h0, mem_read}, 32'h0);
    chk("wr_addr", mem_address, 32'h00000020);
    chk("wr_data", mem_write_data, 32'h12345678);
    chk("wr_grant", {31'h0, grant}, 32'h1);
    chk("wr_m0_ack_low", {31'h0, m0_ack}, 32'h0);
    tick();
    chk("wr_ack", {31'h0, m1_ack}, 32'h1);
    chk("wr_m0_ack_never", {31'h0, m0_ack}, 32'h0);
    m1_write = 1'b0;
    tick();
    chk("wr_ack_pulse", {30'h0, m0_ack, m1_ack}, 32'h0);
    chk("wr_idle_busy", {31'h0, busy}, 32'h0);

    // Contention: both read continuously; loader was served last
    m0_read = 1'b1; m1_read = 1'b1; m0_address = 32'h00000100; m1_address = 32'h00000200;
    for (int k = 0; k < 4; k++) begin
`ifdef ROUND_ROBIN_EN
      exp_g = (k % 2 == 1);
`else
      exp_g = 1'b0;
`endif
      mem_val1 = 32'h00001000 + 32'(k);
      n = 0;
      while (!mem_read && n < 10) begin
        tick();
        n++;
      end
      chk("cont_strobe", {31'h0, mem_read}, 32'h1);
      chk("cont_grant", {31'h0, grant}, {31'h0, exp_g});
      chk("cont_addr", mem_address, exp_g ? 32'h00000200 : 32'h00000100);
      tick(); tick();
      chk("cont_acks", {30'h0, m1_ack, m0_ack}, exp_g ? 32'h2 : 32'h1);
      chk("cont_data", exp_g ? m1_read_data : m0_read_data, 32'h00001000 + 32'(k));
    end
    m0_read = 1'b0; m1_read = 1'b0;
    tick();

    // Reset during WAIT aborts, reissued read completes
    mem_val1 = 32'hCAFEF00D; m0_address = 32'h00000050; m0_read = 1'b1;
    tick(); tick();
    chk("abort_in_wait_busy", {31'h0, busy}, 32'h1);
    reset = 1'b1;
    #1;
    chk("abort_busy", {31'h0, busy}, 32'h0);
    chk("abort_no_ack", {30'h0, m0_ack, m1_ack}, 32'h0);
    tick();
    chk("abort_busy2", {31'h0, busy}, 32'h0);
    chk("abort_no_ack2", {31'h0, m0_ack}, 32'h0);
    chk("abort_rdata_clr", m0_read_data, 32'h0);
    reset = 1'b0;
    n = 0;
    while (!m0_ack && n < 12) begin
      tick();
      n++;
    end
    chk("reissue_ack", {31'h0, m0_ack}, 32'h1);
    chk("reissue_latency", 32'(n), 32'd3);
    chk("reissue_data", m0_read_data, 32'hCAFEF00D);
    m0_read = 1'b0;
    tick();
    chk("reissue_ack_pulse", {31'h0, m0_ack}, 32'h0);

    // READ_LATENCY = 3 instance
    d3_m0_address = 32'h00000040; d3_m0_read = 1'b1;
    tick();
    chk("l3_strobe", {31'h0, d3_mem_read}, 32'h1);
    chk("l3_addr", d3_mem_address, 32'h00000040);
    tick(); tick(); tick();
    chk("l3_no_early_ack", {31'h0, d3_m0_ack}, 32'h0);
    chk("l3_busy", {31'h0, d3_busy}, 32'h1);
    tick();
    chk("l3_ack", {31'h0, d3_m0_ack}, 32'h1);
    chk("l3_data", d3_m0_read_data, 32'h3C3C3C3C);
    d3_m0_read = 1'b0;
    tick();
    chk("l3_ack_pulse", {31'h0, d3_m0_ack}, 32'h0);
    chk("l3_idle", {31'h0, d3_busy}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
